descriptor_send_queue: RTL

Parametrised successor of the frame-parser descriptor sender. It pairs each parsed descriptor with the packet buffer ID granted for that frame and overlays the buffer ID into the descriptor's low bits. Paired descriptors are queued in a small FIFO and presented downstream under a hold-until-ack handshake, which decouples parsing from the lookup/queue stage. Frames that cannot be enqueued have their buffer ID returned to the buffer manager and are counted in drop statistics.

---
 rtl/descriptor_send_queue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/descriptor_send_queue.sv
// rtl/descriptor_send_queue.sv - pairs descriptors with buffer IDs, queues them, hold-until-ack output
module descriptor_send_queue #(
  parameter int DESC_W  = 46,
  parameter int BUFID_W = 9,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     i_descriptor_valid,
  input  logic [DESC_W-1:0]        iv_descriptor,
  input  logic                     i_pkt_bufid_wr,
  input  logic [BUFID_W-1:0]       iv_pkt_bufid,
  output logic                     o_pkt_bufid_ack,
  output logic                     o_pkt_bufid_wr,
  output logic [BUFID_W-1:0]       ov_pkt_bufid,
  output logic                     o_bufid_free_wr,
  output logic [BUFID_W-1:0]       ov_bufid_free,
  output logic                     o_descriptor_wr,
  output logic [DESC_W-1:0]        ov_descriptor,
  input  logic                     i_descriptor_ack,
  output logic [$clog2(DEPTH):0]   ov_fifo_used,
  output logic                     o_fifo_full,
  output logic [CNT_W-1:0]         ov_drop_nobuf_cnt,
  output logic [CNT_W-1:0]         ov_drop_full_cnt,
  output logic [1:0]               descriptor_send_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b10
  } state_t;

  state_t            state;
  logic [DESC_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_next;
  logic              push;
  logic              pop;
  logic              drop_full;
  logic              drop_nobuf;
  logic [UW-1:0]     used_next;

  assign descriptor_send_state = state;

  // Decode the incoming frame against last cycle's occupancy; a same-cycle pop never frees a slot.
  always_comb begin
    push       = i_descriptor_valid && i_pkt_bufid_wr && (ov_fifo_used < UW'(DEPTH));
    drop_full  = i_descriptor_valid && i_pkt_bufid_wr && (ov_fifo_used == UW'(DEPTH));
    drop_nobuf = i_descriptor_valid && !i_pkt_bufid_wr;
    pop        = (state == SEND) && i_descriptor_ack;
    rd_next    = rd_ptr + AW'(1);
    used_next  = ov_fifo_used;
    if (push && !pop) begin
      used_next = ov_fifo_used + UW'(1);
    end else if (!push && pop) begin
      used_next = ov_fifo_used - UW'(1);
    end
  end

  // Descriptor storage with the buffer ID overlaid on the low bits.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr] <= {iv_descriptor[DESC_W-1:BUFID_W], iv_pkt_bufid};
    end
  end

  // FIFO pointers and registered occupancy; the presented head stays counted until acked.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ov_fifo_used <= '0;
      o_fifo_full  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      ov_fifo_used <= used_next;
      o_fifo_full  <= (used_next == UW'(DEPTH));
    end
  end

  // Buffer ID acknowledge, forward and return pulses plus saturating drop counters.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      o_pkt_bufid_ack   <= 1'b0;
      o_pkt_bufid_wr    <= 1'b0;
      ov_pkt_bufid      <= '0;
      o_bufid_free_wr   <= 1'b0;
      ov_bufid_free     <= '0;
      ov_drop_nobuf_cnt <= '0;
      ov_drop_full_cnt  <= '0;
    end else begin
      o_pkt_bufid_ack <= push || drop_full;
      o_pkt_bufid_wr  <= push;
      ov_pkt_bufid    <= push ? iv_pkt_bufid : '0;
      o_bufid_free_wr <= drop_full;
      ov_bufid_free   <= drop_full ? iv_pkt_bufid : '0;
      if (drop_nobuf && (ov_drop_nobuf_cnt != '1)) begin
        ov_drop_nobuf_cnt <= ov_drop_nobuf_cnt + CNT_W'(1);
      end
      if (drop_full && (ov_drop_full_cnt != '1)) begin
        ov_drop_full_cnt <= ov_drop_full_cnt + CNT_W'(1);
      end
    end
  end

  // Output FSM: present the head, hold until ack, chain straight to the next queued entry.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state           <= IDLE;
      o_descriptor_wr <= 1'b0;
      ov_descriptor   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ov_fifo_used != '0) begin
            ov_descriptor   <= mem[rd_ptr];
            o_descriptor_wr <= 1'b1;
            state           <= SEND;
          end
        end
        SEND: begin
          if (i_descriptor_ack) begin
            if (ov_fifo_used > UW'(1)) begin
              ov_descriptor   <= mem[rd_next];
              o_descriptor_wr <= 1'b1;
            end else begin
              ov_descriptor   <= '0;
              o_descriptor_wr <= 1'b0;
              state           <= IDLE;
            end
          end
        end
        default: begin
          state           <= IDLE;
          o_descriptor_wr <= 1'b0;
          ov_descriptor   <= '0;
        end
      endcase
    end
  end

endmodule
